// File: rtl/baud_tick_pkg.sv
// Shared types and constants for the UART baud tick scheduler.
package baud_tick_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  localparam int BAUD_DIV_W       = 16;
  localparam int BAUD_OVS         = 16;
  localparam int BAUD_DEFAULT_DIV = 54;
  localparam int BAUD_MIN_DIV     = 2;
  localparam int FRAC_W           = 4;

endpackage

// File: rtl/baud_tick_ctrl_counter.sv
// Modulo counter with synchronous clear and a registered one-cycle terminal pulse.
// wrap_o is the combinational terminal condition, used to chain a second counter.
module mod_tick_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] mod_i,
  output logic         wrap_o,
  output logic         tick_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q;

  // mod_i - 1 is taken in W bits, so a power-of-two modulus truncated to 0 still wraps at 2**W-1.
  assign wrap_o = en_i && (cnt_q == (mod_i - W'(1)));
  assign tick_o = tick_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= wrap_o && !clr_i;
    end
  end

endmodule

// File: rtl/baud_tick_ctrl.sv
// Baud / 16x oversample clock-enable scheduler with a boundary-synchronised divisor update port.
// Optional fractional divisor build: define BAUD_TICK_FRAC_DIV_EN.
module baud_tick_ctrl
  import baud_tick_pkg::*;
#(
  parameter int               DIV_W       = BAUD_DIV_W,
  parameter int               OVS         = BAUD_OVS,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(BAUD_DEFAULT_DIV),
  parameter int               MIN_DIV     = BAUD_MIN_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              cfg_ready,
  output logic              cfg_err,
  output logic [DIV_W-1:0]  cur_div,
  output logic              pending,
  output logic              tick_ovs,
  output logic              tick_baud
);

  localparam int               OVS_W   = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [OVS_W-1:0] OVS_MOD = OVS_W'(OVS);

  state_e           state_q;
  logic [DIV_W-1:0] cur_div_q, held_div_q, ovs_mod;
  logic             pending_q, err_q;

  logic accept, legal, load_direct, hold, apply_held;
  logic run_en, cnt_clr, ovs_wrap, baud_wrap;

  assign cfg_ready = !pending_q;
  assign cfg_err   = err_q;
  assign cur_div   = cur_div_q;
  assign pending   = pending_q;

  assign accept = cfg_valid && cfg_ready;
  assign legal  = cfg_div >= DIV_W'(MIN_DIV);

  // A legal divisor lands immediately when no ticks are running (or are stopping this edge).
  assign load_direct = accept && legal && ((state_q == ST_IDLE) || (state_q == ST_RUN && !en));
  assign hold        = accept && legal && (state_q == ST_RUN) && en;
  assign apply_held  = (state_q == ST_PEND) && (!en || baud_wrap);

  assign run_en  = (state_q != ST_IDLE) && en;
  assign cnt_clr = !en;

`ifdef BAUD_TICK_FRAC_DIV_EN
  logic [FRAC_W-1:0] frac_q, held_frac_q, acc_q;
  logic [FRAC_W:0]   acc_sum;

  // The period whose terminal add carries is stretched by one cycle.
  assign acc_sum = {1'b0, acc_q} + {1'b0, frac_q};
  assign ovs_mod = cur_div_q + {{(DIV_W-1){1'b0}}, acc_sum[FRAC_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      frac_q      <= '0;
      held_frac_q <= '0;
      acc_q       <= '0;
    end else begin
      if (load_direct) frac_q <= cfg_frac;
      if (hold)        held_frac_q <= cfg_frac;
      if (apply_held)  frac_q <= held_frac_q;
      if (!en || load_direct || apply_held) begin
        acc_q <= '0;
      end else if (ovs_wrap) begin
        acc_q <= acc_sum[FRAC_W-1:0];
      end
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^cfg_frac;
  assign ovs_mod     = cur_div_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_div_q  <= DEFAULT_DIV;
      held_div_q <= '0;
      pending_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= accept && !legal;
      case (state_q)
        ST_IDLE: begin
          if (load_direct) cur_div_q <= cfg_div;
          if (en) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (!en) begin
            state_q <= ST_IDLE;
            if (load_direct) cur_div_q <= cfg_div;
          end else if (hold) begin
            held_div_q <= cfg_div;
            pending_q  <= 1'b1;
            state_q    <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (apply_held) begin
            cur_div_q <= held_div_q;
            pending_q <= 1'b0;
            state_q   <= en ? ST_RUN : ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

  mod_tick_counter #(.W(DIV_W)) u_ovs_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (cnt_clr),
    .en_i   (run_en),
    .mod_i  (ovs_mod),
    .wrap_o (ovs_wrap),
    .tick_o (tick_ovs)
  );

  mod_tick_counter #(.W(OVS_W)) u_baud_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (cnt_clr),
    .en_i   (ovs_wrap),
    .mod_i  (OVS_MOD),
    .wrap_o (baud_wrap),
    .tick_o (tick_baud)
  );

endmodule

// File: tb/tb_baud_tick_ctrl.sv
// Directed bench for baud_tick_ctrl: tick spacing, divisor handshake, boundary apply, reset.
module tb_baud_tick_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, cfg_valid;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_frac;
  logic        cfg_ready, cfg_err, pending, tick_ovs, tick_baud;
  logic [15:0] cur_div;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  baud_tick_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_frac  (cfg_frac),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .cur_div   (cur_div),
    .pending   (pending),
    .tick_ovs  (tick_ovs),
    .tick_baud (tick_baud)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycles until the selected tick is next seen high; -1 if it never comes.
  task automatic wait_tick(input bit baud, output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      n++;
      if ((baud ? tick_baud : tick_ovs) === 1'b1) return;
    end
    n = -1;
  endtask

  initial begin
    int n;
    int seen;
    int total;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_frac = '0;
    step(); step();
    rst = 1'b0;

    chk_eq("rst_cur_div", cur_div, 54);
    chk_eq("rst_tick_ovs", tick_ovs, 0);
    chk_eq("rst_tick_baud", tick_baud, 0);
    chk_eq("rst_cfg_err", cfg_err, 0);
    chk_eq("rst_pending", pending, 0);
    chk_eq("rst_cfg_ready", cfg_ready, 1);

    // Default divisor 54
    en = 1'b1;
    step();
    wait_tick(0, n); chk_eq("d54_first_ovs", n, 54);
    wait_tick(0, n); chk_eq("d54_ovs_period", n, 54);
    wait_tick(1, n); chk_eq("d54_first_baud", n, 756);
    chk_eq("d54_baud_coinc", tick_ovs, 1);
    wait_tick(1, n); chk_eq("d54_baud_period", n, 864);
    chk_eq("d54_baud_coinc2", tick_ovs, 1);

    // Divisor 4 loaded in IDLE
    en = 1'b0;
    step();
    cfg_valid = 1'b1; cfg_div = 16'd4;
    step();
    cfg_valid = 1'b0;
    chk_eq("idle_load_div4", cur_div, 4);
    en = 1'b1;
    step();
    wait_tick(0, n); chk_eq("d4_first_ovs", n, 4);
    wait_tick(0, n); chk_eq("d4_ovs_period", n, 4);
    wait_tick(1, n); chk_eq("d4_first_baud", n, 56);
    wait_tick(1, n); chk_eq("d4_baud_period", n, 64);

    // Illegal divisors 1 and 0 while running
    cfg_valid = 1'b1; cfg_div = 16'd1;
    step();
    cfg_valid = 1'b0;
    chk_eq("err1_pulse", cfg_err, 1);
    chk_eq("err1_ready", cfg_ready, 1);
    chk_eq("err1_pending", pending, 0);
    chk_eq("err1_cur_div", cur_div, 4);
    cfg_valid = 1'b1; cfg_div = 16'd0;
    step();
    cfg_valid = 1'b0;
    chk_eq("err0_pulse", cfg_err, 1);
    chk_eq("err0_cur_div", cur_div, 4);
    step();
    chk_eq("err0_one_cycle", cfg_err, 0);
    step();
    chk_eq("err_tick_kept", tick_ovs, 1);
    wait_tick(0, n); chk_eq("err_ovs_period", n, 4);

    // Divisor 8 requested mid-bit: held until the baud boundary
    step(); step();
    cfg_valid = 1'b1; cfg_div = 16'd8;
    step();
    cfg_div = 16'd10;
    chk_eq("pend_set", pending, 1);
    chk_eq("pend_ready_low", cfg_ready, 0);
    wait_tick(0, n); chk_eq("pend_partial_ovs", n, 1);
    wait_tick(0, n); chk_eq("pend_old_period", n, 4);
    chk_eq("pend_old_div", cur_div, 4);
    wait_tick(1, n); chk_eq("pend_to_boundary", n, 48);
    chk_eq("apply_div8", cur_div, 8);
    chk_eq("apply_pending_clr", pending, 0);
    chk_eq("apply_ready", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    chk_eq("second_req_held", pending, 1);
    chk_eq("second_req_div", cur_div, 8);
    wait_tick(0, n); chk_eq("d8_ovs_rest", n, 7);
    wait_tick(0, n); chk_eq("d8_ovs_period", n, 8);

    // en dropped while holding divisor 10
    en = 1'b0;
    step();
    chk_eq("drop_cur_div", cur_div, 10);
    chk_eq("drop_pending", pending, 0);
    chk_eq("drop_ready", cfg_ready, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick_ovs === 1'b1 || tick_baud === 1'b1) seen++;
    end
    chk_eq("idle_no_ticks", seen, 0);
    en = 1'b1;
    step();
    wait_tick(0, n); chk_eq("d10_first_ovs", n, 10);
    wait_tick(0, n); chk_eq("d10_ovs_period", n, 10);

    // Reset mid-run on a tick edge with a request presented
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1; cfg_valid = 1'b1; cfg_div = 16'd20;
    step();
    chk_eq("mrst_tick_ovs", tick_ovs, 0);
    chk_eq("mrst_cur_div", cur_div, 54);
    chk_eq("mrst_pending", pending, 0);
    chk_eq("mrst_ready", cfg_ready, 1);
    chk_eq("mrst_err", cfg_err, 0);
    rst = 1'b0; cfg_valid = 1'b0; en = 1'b0;
    step();

`ifdef BAUD_TICK_FRAC_DIV_EN
    cfg_valid = 1'b1; cfg_div = 16'd4; cfg_frac = 4'd8;
    step();
    cfg_valid = 1'b0;
    chk_eq("frac_load_div", cur_div, 4);
    en = 1'b1;
    step();
    total = 0;
    for (int i = 0; i < 16; i++) begin
      wait_tick(0, n);
      if (i < 2) chk_eq("frac_period", n, (i == 0) ? 4 : 5);
      total += n;
    end
    chk_eq("frac_16_span", total, 72);
`else
    total = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/baud_tick_ctrl.md
Name: baud_tick_ctrl

Overview:
- Runtime-configurable baud-rate tick scheduler for the UART interface.
- Replaces derived-clock division with single-cycle clock-enable ticks in the system clock domain:
  - 16x oversample tick for the RX sampler.
  - 1x baud tick for the TX shifter.
- Owns the divisor register and a valid/ready config port. A new divisor takes effect only on a baud-bit boundary.

Parameters:
- DIV_W, 16, width of divisor and counters.
- OVS, 16, oversample ticks per baud tick (power of two, ≥2).
- DEFAULT_DIV, 16'd54, divisor loaded at reset (100 MHz / (115200 × 16)).
- MIN_DIV, 2, smallest legal divisor.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  run enable; low holds counters cleared.
- cfg_valid  in  1  config request.
- cfg_div  in  DIV_W  requested divisor.
- cfg_frac  in  4  fractional part, sixteenths (used only with FRAC_DIV_EN).
- cfg_ready  out  1  config slot available.
- cfg_err  out  1  one-cycle pulse: accepted request was rejected (div < MIN_DIV).
- cur_div  out  DIV_W  divisor currently in use.
- pending  out  1  accepted divisor waiting for a baud boundary.
- tick_ovs  out  1  oversample enable pulse.
- tick_baud  out  1  baud enable pulse; always coincides with a tick_ovs.

Behaviour:
- **Reset values** (rst high at a clk edge):
  - state=IDLE, cur_div=DEFAULT_DIV, ovs_cnt=0, baud_cnt=0.
  - tick_ovs=0, tick_baud=0, cfg_err=0, pending=0, cfg_ready=1.
  - Pending divisor is discarded.
- **States**
  - IDLE (en=0):
    - Counters held at 0; no ticks.
    - Accepted legal divisor loads into cur_div on the next edge.
  - RUN (en=1, nothing pending):
    - ovs_cnt counts 0..cur_div-1.
    - At terminal: ovs_cnt←0, tick_ovs=1 for the following cycle, baud_cnt increments mod OVS.
    - tick_baud=1 in the same cycle as the tick_ovs that wraps baud_cnt from OVS-1 to 0.
  - PEND (en=1, divisor held):
    - Ticks continue on the old cur_div.
    - On the edge that produces tick_baud: cur_div←held value, both counters←0, go to RUN.
- **Transitions**
  - IDLE→RUN when en=1.
  - RUN/PEND→IDLE when en=0:
    - Counters cleared next edge.
    - A held divisor is applied immediately into cur_div; pending←0.
- **Handshake**
  - Transfer on cfg_valid & cfg_ready.
  - cfg_ready = !pending (high in IDLE and RUN, low in PEND).
  - cfg_div < MIN_DIV: request is consumed and cfg_err pulses on the next cycle. State and cur_div are unchanged.
  - Legal accept in RUN sets pending=1 on the next edge.
- **Timing**
  - Registered outputs; every tick is exactly one cycle wide.
  - First tick_ovs appears cur_div cycles after the first edge at which en is sampled high.
  - tick_ovs period = cur_div cycles.
  - tick_baud period = OVS × cur_div cycles.
- **Arithmetic**
  - Counters are DIV_W and clog2(OVS) bits wide.
  - Terminal compare is against cur_div-1 computed in DIV_W bits; legal divisors never underflow.
- **Simultaneous events**
  - en falling and cfg accept on the same edge: apply the divisor as in IDLE.
  - Accept on the same edge as a tick_baud in RUN: the change waits for the next baud boundary.
  - rst dominates all other inputs.

Optional Feature:
- Macro: BAUD_TICK_FRAC_DIV_EN.
- **Defined:**
  - cfg_frac is captured alongside cfg_div and applied at the same time.
  - A 4-bit phase accumulator adds frac on every oversample terminal; on carry, that period lasts cur_div+1 cycles.
  - Mean period = cur_div + frac/16.
  - Accumulator clears on reset, on en low and on divisor apply.
- **Undefined:** cfg_frac is ignored, no accumulator is built, every period is exactly cur_div.

Decomposition:
- Package baud_tick_pkg:
  - state encoding (IDLE, RUN, PEND).
  - DEFAULT_DIV, MIN_DIV, OVS constants.
  - Width of cfg_frac.
- Sub-module mod_tick_counter (modulus input, enable, clear, registered terminal pulse), instantiated twice:
  - Oversample counter.
  - Baud counter with modulus OVS.

Test Plan:
- Reset, en=1, cur_div=54 → first tick_ovs 54 cycles after en; tick_ovs every 54 cycles; tick_baud every 864 cycles, coincident with a tick_ovs.
- In IDLE, cfg_div=4 accepted → cur_div=4 next cycle; after en=1, tick_ovs every 4 cycles, tick_baud every 64 cycles.
- In RUN at div 4, cfg_div=8 accepted mid-bit → pending=1, cfg_ready=0; old 4-cycle ticks continue until tick_baud; then cur_div=8 and 8-cycle spacing; a second request is held off until then.
- cfg_div=1 (and 0) → cfg_err one-cycle pulse; cur_div, state, tick spacing unchanged; cfg_ready stays 1.
- en dropped while PEND with held div 10 → ticks stop next cycle, cur_div=10, pending=0; re-enable gives 10-cycle spacing.
- BAUD_TICK_FRAC_DIV_EN with div 4, frac 8 → tick_ovs spacing alternates 4,5; 16 ticks span 72 cycles. rst asserted mid-run → all outputs to reset values on the next edge.
